// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FP multiplier scheduler.
// No logic: constants, state encodings and the round-robin pointer step.
// No flow control of its own.
package fpu_mul_pkg;

  localparam int SIZE_DATA = 32;
  localparam int MAX_REQ   = 8;

  // Wide enough for the largest supported requester count.
  typedef logic [$clog2(MAX_REQ)-1:0] req_id_t;

  typedef logic [1:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE  = 2'd0;
  localparam fsm_state_t ST_RUN   = 2'd1;
  localparam fsm_state_t ST_DRAIN = 2'd2;

  function automatic int rr_next(input int id, input int n);
    return (id >= n - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, searching upward from ptr with wrap.
// Latency: combinational.
// Backpressure: none; the caller masks req to suppress grants.
module rr_arbiter
  import fpu_mul_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_id_t            ptr,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_id
);

  int   idx;
  logic found;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = req_id_t'(idx);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_mul_sched.sv
// Shares one fixed-latency FP multiplier among NUM_REQ requesters (round robin); FPU_MUL_SCHED_STATS_EN adds o_grant_cnt.
// Latency: grant to multiplier is combinational; o_rsp_valid returns exactly MUL_LAT cycles after the grant.
// Backpressure: one grant per cycle via o_req_ready; i_drain stops grants; responses cannot be stalled.
module fpu_mul_sched
  import fpu_mul_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MUL_LAT   = 3,
  parameter int SIZE_DATA = fpu_mul_pkg::SIZE_DATA
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_a,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_b,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_mul_valid,
  output logic [SIZE_DATA-1:0]           o_mul_a,
  output logic [SIZE_DATA-1:0]           o_mul_b,
  input  logic [SIZE_DATA-1:0]           i_mul_result,
  output logic [NUM_REQ-1:0]             o_rsp_valid,
  output logic [SIZE_DATA-1:0]           o_rsp_data,
  input  logic                           i_drain,
  output logic                           o_idle
`ifdef FPU_MUL_SCHED_STATS_EN
  ,
  output logic [15:0]                    o_grant_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  fsm_state_t          state, state_nxt;
  req_id_t             ptr, gnt_id;
  logic [NUM_REQ-1:0]  req_elig, gnt;
  logic                gnt_en, any_gnt, any_req, pipe_empty;
  logic [MUL_LAT-1:0]  vld_sr;
  logic [ID_W-1:0]     id_sr [MUL_LAT];

  // IDLE grants like RUN; a drain request wins over a grant in the same cycle.
  assign gnt_en   = i_rst_n && !i_drain && (state != ST_DRAIN);
  assign req_elig = gnt_en ? i_req_valid : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_elig),
    .ptr      (ptr),
    .grant    (gnt),
    .grant_id (gnt_id)
  );

  assign o_req_ready = gnt;
  assign any_gnt     = |gnt;
  assign o_mul_valid = any_gnt;
  assign any_req     = |i_req_valid;
  assign pipe_empty  = ~|vld_sr;
  assign o_idle      = pipe_empty && (state != ST_RUN);

  always_comb begin
    o_mul_a = '0;
    o_mul_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        o_mul_a = i_req_a[i*SIZE_DATA +: SIZE_DATA];
        o_mul_b = i_req_b[i*SIZE_DATA +: SIZE_DATA];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      o_rsp_valid[i] = vld_sr[MUL_LAT-1] && (id_sr[MUL_LAT-1] == ID_W'(i));
    end
    o_rsp_data = vld_sr[MUL_LAT-1] ? i_mul_result : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (any_req && !i_drain) state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_drain)                       state_nxt = ST_DRAIN;
        else if (!any_req && pipe_empty)   state_nxt = ST_IDLE;
      end
      ST_DRAIN: if (!i_drain && pipe_empty) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (any_gnt) ptr <= req_id_t'(rr_next(int'(gnt_id), NUM_REQ));
    end
  end

  // Slot k holds the operation issued k+1 cycles ago; the last slot is the one returning now.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_sr <= '0;
      for (int k = 0; k < MUL_LAT; k++) id_sr[k] <= '0;
    end else begin
      vld_sr[0] <= any_gnt;
      id_sr[0]  <= gnt_id[ID_W-1:0];
      for (int k = 1; k < MUL_LAT; k++) begin
        vld_sr[k] <= vld_sr[k-1];
        id_sr[k]  <= id_sr[k-1];
      end
    end
  end

`ifdef FPU_MUL_SCHED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_grant_cnt <= '0;
    end else if (any_gnt && (o_grant_cnt != 16'hFFFF)) begin
      o_grant_cnt <= o_grant_cnt + 16'd1;
    end
  end
`endif

endmodule
